// File: rtl/hash_mem_responder_if.sv
// Bus bundle for hash_mem_responder: initiator port, preload port, clear
// request and the status/counter outputs.
interface hash_mem_responder_if #(
    parameter int DEPTH = 256
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              mem_we;
    logic [15:0]       mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;
    logic              pl_we;
    logic [IDX_W-1:0]  pl_idx;
    logic [31:0]       pl_data;
    logic              clr;
    logic              busy;
    logic [15:0]       rd_cnt;
    logic [15:0]       wr_cnt;
    logic [7:0]        err_cnt;
    logic              err;

    modport master (
        output mem_we, mem_addr, mem_write_data, pl_we, pl_idx, pl_data, clr,
        input  mem_read_data, busy, rd_cnt, wr_cnt, err_cnt, err
    );

    modport slave (
        input  mem_we, mem_addr, mem_write_data, pl_we, pl_idx, pl_data, clr,
        output mem_read_data, busy, rd_cnt, wr_cnt, err_cnt, err
    );
endinterface

// File: rtl/hash_mem_responder.sv
// Windowed 32-bit word memory with a preload port, a clear sweep FSM and
// access/error counters. Reads have one cycle of latency.
module hash_mem_responder #(
    parameter int          DEPTH = 256,
    parameter logic [15:0] BASE  = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    hash_mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            r_state;
    logic [31:0]       r_mem [DEPTH];
    logic [IDX_W-1:0]  r_clr_idx;
    logic [31:0]       r_rd_data;
    logic              r_busy;
    logic [15:0]       r_rd_cnt;
    logic [15:0]       r_wr_cnt;
    logic [7:0]        r_err_cnt;
    logic              r_err;
    logic [15:0]       r_prev_addr;

    logic [16:0]       w_off;
    logic              w_in_win;
    logic [IDX_W-1:0]  w_idx;
    logic              w_collide;
    logic              w_do_wr;
    logic [1:0]        w_err_inc;
    logic [8:0]        w_err_sum;

    // 17-bit offset: addresses below BASE land above 16'hFFFF and fall out of window
    assign w_off     = {1'b0, bus.mem_addr} - {1'b0, BASE};
    assign w_in_win  = (w_off < 17'(DEPTH));
    assign w_idx     = w_off[IDX_W-1:0];
    assign w_collide = bus.pl_we && (bus.pl_idx == w_idx);
    assign w_do_wr   = (r_state == IDLE) && bus.mem_we && w_in_win && !w_collide;
    assign w_err_sum = {1'b0, r_err_cnt} + 9'(w_err_inc);

    always_comb begin
        w_err_inc = 2'd0;
        if (r_state == CLEAR) begin
            w_err_inc = {1'b0, bus.pl_we}
                      + {1'b0, (bus.mem_we || (bus.mem_addr != r_prev_addr))};
        end else if (!w_in_win || (bus.mem_we && w_collide)) begin
            w_err_inc = 2'd1;
        end
    end

    // Array has no reset; reset only blocks writes in its own cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_idx] <= '0;
            end else begin
                if (bus.pl_we) r_mem[bus.pl_idx] <= bus.pl_data;
                if (w_do_wr)   r_mem[w_idx]      <= bus.mem_write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_prev_addr <= bus.mem_addr;
        if (reset) begin
            r_state   <= IDLE;
            r_clr_idx <= '0;
            r_busy    <= 1'b0;
            r_rd_data <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_err_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_err_inc != 2'd0) begin
                r_err     <= 1'b1;
                r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            end
            if (r_state == IDLE) begin
                if (!bus.mem_we) begin
                    if (w_in_win) begin
                        r_rd_data <= r_mem[w_idx];
                        r_rd_cnt  <= r_rd_cnt + 16'd1;
                    end else begin
                        r_rd_data <= '0;
                    end
                end
                if (w_do_wr) r_wr_cnt <= r_wr_cnt + 16'd1;
                if (bus.clr) begin
                    r_state   <= CLEAR;
                    r_busy    <= 1'b1;
                    r_clr_idx <= '0;
                end
            end else begin
                if (!bus.mem_we) r_rd_data <= '0;
                r_clr_idx <= r_clr_idx + IDX_W'(1);
                if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign bus.mem_read_data = r_rd_data;
    assign bus.busy          = r_busy;
    assign bus.rd_cnt        = r_rd_cnt;
    assign bus.wr_cnt        = r_wr_cnt;
    assign bus.err_cnt       = r_err_cnt;
    assign bus.err           = r_err;
endmodule

// File: doc/hash_mem_responder.md
HASH_MEM_RESPONDER -- requirements
Module: hash_mem_responder

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- DEPTH, 256, number of 32-bit words (power of two, 16..1024).
- BASE, 16'h0000, first word address decoded by the block.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high reset.
- mem_we, in, 1, initiator write enable.
- mem_addr, in, 16, initiator word address.
- mem_write_data, in, 32, initiator write data.
- mem_read_data, out, 32, registered read data.
- pl_we, in, 1, preload write strobe.
- pl_idx, in, log2(DEPTH), preload word index relative to BASE.
- pl_data, in, 32, preload data.
- clr, in, 1, single-cycle request to zero the whole array.
- busy, out, 1, high while a clear sweep runs.
- rd_cnt, out, 16, count of accepted in-window reads.
- wr_cnt, out, 16, count of accepted in-window writes.
- err_cnt, out, 8, count of rejected accesses.
- err, out, 1, sticky error flag.
REQ-003 There SHALL be one clock and one reset only: clk, plus reset (synchronous, active-high).

Function
REQ-004 An access SHALL be in-window when BASE <= mem_addr <= BASE+DEPTH-1; index = mem_addr-BASE, computed in 16 bits with no wrap past 16'hFFFF.
REQ-005 Each cycle with mem_we=0 SHALL be a read: mem_read_data updates at the next edge, giving 1-cycle latency; the initiator presents address N in cycle t and samples data in cycle t+1.
REQ-006 A write (mem_we=1, in-window, FSM IDLE) SHALL update array[index] at the edge; mem_read_data SHALL hold its previous value on write cycles.
REQ-007 A read and a write to the same index cannot coincide (single port); a read in the cycle after a write SHALL return the new data.
REQ-008 An out-of-window read SHALL return 32'h0000_0000; an out-of-window write SHALL be dropped; both SHALL increment err_cnt and set err.
REQ-009 A preload (pl_we=1) SHALL write array[pl_idx]=pl_data at the edge in any FSM state except CLEAR.
REQ-010 Preload plus an in-window initiator write to the same index in the same cycle: preload SHALL win, the initiator write SHALL be dropped and counted in err_cnt, and wr_cnt SHALL not increment.
REQ-011 Preload plus an initiator write to different indices SHALL perform both writes.
REQ-012 The FSM SHALL have two states, IDLE and CLEAR. In IDLE, clr=1 SHALL go to CLEAR with clr_idx=0.
REQ-013 In CLEAR the block SHALL write array[clr_idx]=0 and increment clr_idx each cycle, returning to IDLE after writing index DEPTH-1. CLEAR SHALL last exactly DEPTH cycles, with busy=1 throughout.
REQ-014 During CLEAR, clr SHALL be ignored; pl_we SHALL be ignored and count as an error.
REQ-015 During CLEAR, initiator reads SHALL return 0 and initiator writes SHALL be dropped; each counts as an error, except idle reads at a constant address, which SHALL count nothing.
REQ-016 rd_cnt and wr_cnt SHALL increment by 1 per accepted access and wrap 16'hFFFF->0.
REQ-017 err_cnt SHALL saturate at 8'hFF, and err SHALL stay 1 until reset.
REQ-018 Array contents SHALL be undefined after power-up; reset SHALL NOT clear the array.

Reset
REQ-019 While reset=1 at an edge, the block SHALL force the following: FSM=IDLE, clr_idx=0, busy=0, mem_read_data=0, rd_cnt=0, wr_cnt=0, err_cnt=0, err=0.
REQ-020 Reset SHALL take priority over clr, pl_we and mem_we in the same cycle.
REQ-021 Reset during CLEAR SHALL abort the sweep, leaving the already-cleared words at 0 and the rest unchanged.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Preload idx 0..19 with 32'h1000_0000+i, BASE=16'h0000, read addr 0..19 back-to-back -> each word appears 1 cycle after its address; rd_cnt=20; err=0.
- Write 32'hCAFE_F00D at addr 5, read addr 5 next cycle -> 32'hCAFE_F00D; wr_cnt=1.
- BASE=16'h0100, read addr 16'h00FF and 16'h0200 -> data 0 both times; err_cnt=2; err=1.
- Same cycle: pl_we idx 3 = 32'h1111_1111 and mem write addr 3 = 32'h2222_2222 -> read of 3 gives 32'h1111_1111; err_cnt=1; wr_cnt=0.
- clr pulse with DEPTH=256 -> busy high exactly 256 cycles; all reads afterward return 0; reset asserted at sweep cycle 10 -> idx 0..9 read 0, idx 10+ keep prior values, busy=0.
- 65,536 accepted writes -> wr_cnt wraps to 0; 300 out-of-window accesses -> err_cnt holds at 8'hFF.
